mask_deserializer: RTL
======================

# mask_deserializer

Downstream consumer of the bit-serial row-mask stage in the UKF accelerator. Samples the four lanes `data_in1..data_in4` (8 bits each, LSB first, lane k carries word bits 4*i+k), rebuilds the 32-bit lower-triangular row mask, and derives its active-row count and a thermometer-form flag. Presents the result to the Cholesky/lower-update control through a valid/ready handshake.

## Interface
- `LANES`, 4: serial lanes; fixed at 4.
- `BITS_PER_LANE`, 8: bits per lane per frame; fixed at 8.
- `clock` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `lane_en` input 1: frame enable, the same signal that drives the serializer (`lower_start1 || data_available_lower`).
- `data_in1..data_in4` input 1 each: serial lanes 0..3.
- `mask_ready` input 1: consumer accepts `mask_word` when high with `mask_valid`.
- `mask_word` output 32: reassembled mask.
- `mask_valid` output 1: `mask_word`, `active_count` and `thermo` are valid.
- `active_count` output 6: popcount of `mask_word`, range 0..32.
- `thermo` output 1: high when `mask_word` equals 2^n−1 for some n in 0..32.
- `frame_abort` output 1: one-cycle pulse when a frame is cut short.
- `overrun` output 1: sticky; a completed word was dropped.

## Operation
- States:
  - IDLE: waiting for a frame.
  - SHIFT: bit counter `b` runs 0..7.
  - WAIT_LOW: frame complete, but `lane_en` is still high.
- IDLE → SHIFT on the first edge that samples `lane_en`=1. That edge, E0, sets `b`=0 and captures nothing, because the serializer registers bit 0 at E0.
- SHIFT, at edges E1..E8 with `lane_en`=1: store lane k bit into `shreg[4*b+k]`, then `b`++.
  - At E8 the full word (`shreg` plus the current bits) loads the output register.
  - Next state is WAIT_LOW if `lane_en` is 1, otherwise IDLE.
- SHIFT, at any edge E1..E8 with `lane_en`=0: discard the partial word, pulse `frame_abort`, go to IDLE. The output register is untouched.
- WAIT_LOW: ignore the lanes (the serializer drives zeros). Go to IDLE on the first edge sampling `lane_en`=0. Re-arming needs `lane_en` low for at least one edge.
- Output register load at E8:
  - If `mask_valid`=0, or `mask_ready`=1 on that same edge: load `mask_word`, `active_count`, `thermo`; set `mask_valid`=1.
  - Otherwise: drop the new word, keep the held one, set `overrun`=1.
- Accept: at an edge with `mask_valid` && `mask_ready` and no simultaneous load, clear `mask_valid`. Outputs hold their values until the next load.
- `thermo` = (`mask_word` & (`mask_word`+1)) == 0, evaluated at 33-bit width. 0 and 0xFFFFFFFF both give 1.
- `overrun` clears only on reset.

## Timing
- Reset values: `mask_word`=0, `mask_valid`=0, `active_count`=0, `thermo`=0, `frame_abort`=0, `overrun`=0, state IDLE, `b`=0, `shreg`=0.
- Latency: `mask_valid` rises immediately after E8, i.e. 9 edges after the first sampled `lane_en`=1.
- `frame_abort` is high for exactly the one cycle after the aborting edge.
- Reset mid-frame: immediate return to IDLE. No abort pulse is generated. The next frame needs a fresh `lane_en` rising, which is sampled after `reset_n` deasserts.
- Back-to-back frames: minimum spacing is 10 edges (E0..E8, WAIT_LOW/IDLE exit, one low edge).
- `mask_ready` can be high at any time and has no combinational path to any output.

## Structure
- Shared package `ukf_mask_pkg`:
  - constants `LANES`=4, `BITS_PER_LANE`=8, `MASK_W`=32, `CNT_W`=6;
  - enum `mask_des_state_t` {IDLE, SHIFT, WAIT_LOW}.
- Sub-module `mask_popcount`: combinational 32→6 adder tree, instantiated once on the assembled word.
- Everything else lives in one always_ff plus next-state logic.

## Test plan
- Serializer with size=6 (mask 0x0000001F), `mask_ready`=1 → `mask_valid` after 9 edges; `mask_word`=0x0000001F, `active_count`=5, `thermo`=1.
- size=33 (0xFFFFFFFF) → `active_count`=32, `thermo`=1. Lanes driven to encode 0x000000A5 → `active_count`=4, `thermo`=0.
- `lane_en` dropped after E4 → `frame_abort` pulses one cycle, `mask_valid` stays 0. A following full 0x3F frame completes normally.
- `mask_ready`=0, two frames 0x7 then 0xFF → `mask_word` stays 0x7, `overrun`=1. Raising `mask_ready` clears `mask_valid`; `overrun` stays 1.
- `mask_ready` rises on exactly the E8 edge of the second frame while the first word is held → 0xFF loads, `mask_valid` stays 1, `overrun` stays 0.
- `reset_n` pulsed low at E5 → all outputs 0 immediately. The next 0xF frame yields `mask_word`=0xF, `active_count`=4.

Source files
------------

// File: rtl/ukf_mask_pkg.sv
// Shared constants and state encoding for the row-mask deserializer.
package ukf_mask_pkg;

    localparam int LANES         = 4;
    localparam int BITS_PER_LANE = 8;
    localparam int MASK_W        = 32;
    localparam int CNT_W         = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_LOW = 2'd2
    } mask_des_state_t;

endpackage

// File: rtl/mask_deserializer_if.sv
// Result bus from the deserializer to the Cholesky/lower-update control.
// Handshake: a word transfers on every rising clock edge where mask_valid and
// mask_ready are both high; mask_valid stays high and the payload stays stable
// until that edge, and mask_ready may be high at any time.
interface mask_deserializer_if;
    import ukf_mask_pkg::*;

    logic [MASK_W-1:0] mask_word;
    logic              mask_valid;
    logic              mask_ready;
    logic [CNT_W-1:0]  active_count;
    logic              thermo;

    modport master (
        output mask_word,
        output mask_valid,
        output active_count,
        output thermo,
        input  mask_ready
    );

    modport slave (
        input  mask_word,
        input  mask_valid,
        input  active_count,
        input  thermo,
        output mask_ready
    );

endinterface

// File: rtl/mask_popcount.sv
// Combinational 32 -> 6 population count built as a balanced adder tree.
module mask_popcount
    import ukf_mask_pkg::*;
(
    input  logic [MASK_W-1:0] word,
    output logic [CNT_W-1:0]  count
);

    logic [1:0] lvl1 [16];
    logic [2:0] lvl2 [8];
    logic [3:0] lvl3 [4];
    logic [4:0] lvl4 [2];

    // Level 1: add adjacent bit pairs.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lvl1[i] = {1'b0, word[2*i]} + {1'b0, word[2*i+1]};
        end
    end

    // Level 2: add adjacent 2-bit sums.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
    end

    // Level 3: add adjacent 3-bit sums.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
    end

    // Level 4: add adjacent 4-bit sums.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        end
    end

    // Final stage: 0..32 fits in six bits.
    always_comb begin
        count = {1'b0, lvl4[0]} + {1'b0, lvl4[1]};
    end

endmodule

// File: rtl/mask_deserializer.sv
// Rebuilds the 32-bit lower-triangular row mask from four LSB-first serial
// lanes, registers it with its popcount and thermometer flag, and hands it
// downstream through a valid/ready register slice.
module mask_deserializer
    import ukf_mask_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                lane_en,
    input  logic                data_in1,
    input  logic                data_in2,
    input  logic                data_in3,
    input  logic                data_in4,
    mask_deserializer_if.master mask_bus,
    output logic                frame_abort,
    output logic                overrun,
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_SHIFT    = SHIFT;
    localparam logic [1:0] S_WAIT_LOW = WAIT_LOW;
    localparam logic [2:0] LAST_BIT   = 3'(BITS_PER_LANE - 1);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [2:0]        b;
    logic [MASK_W-1:0] shreg;
    logic [MASK_W-1:0] asm_word;
    logic [LANES-1:0]  lanes;
    logic [CNT_W-1:0]  asm_count;
    logic [MASK_W:0]   asm_ext;
    logic              asm_thermo;
    logic              frame_done;
    logic              load_ok;

    assign lanes     = {data_in4, data_in3, data_in2, data_in1};
    assign state_dbg = state;

    // Current word: stored bits plus this edge's lane bits at 4*b+k.
    always_comb begin
        asm_word = shreg;
        for (int k = 0; k < LANES; k++) begin
            asm_word[{b, 2'(k)}] = lanes[k];
        end
    end

    mask_popcount u_popcount (
        .word  (asm_word),
        .count (asm_count)
    );

    // A value is 2^n-1 exactly when adding one clears every set bit; the
    // extra top bit lets all-ones wrap cleanly.
    always_comb begin
        asm_ext    = {1'b0, asm_word};
        asm_thermo = ((asm_ext & (asm_ext + 33'd1)) == '0);
    end

    // E8 detection and whether the output slot can take the new word.
    always_comb begin
        frame_done = (state == S_SHIFT) && lane_en && (b == LAST_BIT);
        load_ok    = frame_done && (!mask_bus.mask_valid || mask_bus.mask_ready);
    end

    // Next-state logic; a frame only re-arms after lane_en has been low.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (lane_en) state_nx = S_SHIFT;
            S_SHIFT: begin
                if (!lane_en)             state_nx = S_IDLE;
                else if (b == LAST_BIT)   state_nx = S_WAIT_LOW;
            end
            S_WAIT_LOW: if (!lane_en) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Shift register, bit counter, output slice and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= S_IDLE;
            b                     <= '0;
            shreg                 <= '0;
            frame_abort           <= 1'b0;
            overrun               <= 1'b0;
            mask_bus.mask_word    <= '0;
            mask_bus.mask_valid   <= 1'b0;
            mask_bus.active_count <= '0;
            mask_bus.thermo       <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_abort <= 1'b0;

            case (state)
                S_SHIFT: begin
                    if (!lane_en) begin
                        frame_abort <= 1'b1;
                        b           <= '0;
                        shreg       <= '0;
                    end else if (b == LAST_BIT) begin
                        b     <= '0;
                        shreg <= '0;
                    end else begin
                        b     <= b + 3'd1;
                        shreg <= asm_word;
                    end
                end
                default: b <= '0;
            endcase

            if (load_ok) begin
                mask_bus.mask_word    <= asm_word;
                mask_bus.active_count <= asm_count;
                mask_bus.thermo       <= asm_thermo;
                mask_bus.mask_valid   <= 1'b1;
            end else if (frame_done) begin
                overrun <= 1'b1;
            end else if (mask_bus.mask_valid && mask_bus.mask_ready) begin
                mask_bus.mask_valid <= 1'b0;
            end
        end
    end

endmodule
